mem_arbiter: RTL and testbench

//  Shares the single main-memory port between I-cache and D-cache line refills / D-cache writebacks.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache refills and D-cache refills/writebacks.
// Fixed-length word bursts, one owner at a time, round-robin on simultaneous requests.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cache_stall
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF    = BEAT_W + 2;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    own_t              last_gnt_q, last_gnt_d;
    own_t              owner_q, owner_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            last_gnt_q <= OWN_I;
            owner_q    <= OWN_I;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the requester that did not win last time gets the port
                    if (i_req && d_req) owner_d = (last_gnt_q == OWN_I) ? OWN_D : OWN_I;
                    else                owner_d = d_req ? OWN_D : OWN_I;
                    last_gnt_d = owner_d;
                    beat_d     = '0;
                    state_d    = (owner_d == OWN_D) ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        d_wready  = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state_q)
            GNT_I: begin
                mem_req  = 1'b1;
                mem_addr = {i_addr[ADDR_W-1:OFF], beat_q, 2'b00};
                i_rvalid = mem_ack;
            end
            GNT_D: begin
                mem_req   = 1'b1;
                mem_we    = d_we;
                mem_addr  = {d_addr[ADDR_W-1:OFF], beat_q, 2'b00};
                mem_wdata = d_we ? d_wdata : '0;
                d_rvalid  = mem_ack & ~d_we;
                d_wready  = mem_ack & d_we;
            end
            DONE: begin
                i_done = (owner_q == OWN_I);
                d_done = (owner_q == OWN_D);
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Stall is forced low while reset is held so the pipeline is never frozen by a reset
    assign cache_stall = rst_n & ((state_q == GNT_I) || (state_q == GNT_D) ||
                                  ((state_q == IDLE) && (i_req || d_req)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level reference of owner / beats-done / done-cycle.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LW     = 4;
    localparam logic [31:0] LINE_MASK = ~32'(LW * 4 - 1);

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid, i_done;
    logic              d_req = 1'b0;
    logic              d_we  = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_wready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid, d_done;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              cache_stall;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cache_stall(cache_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: who owns the port (0 none, 1 I, 2 D), beats completed, owner in its done cycle,
    // and who won the last arbitration (1 I, 2 D)
    int m_own, m_cnt, m_fin, m_last;
    bit seen_idone, seen_ddone, seen_wr;
    bit auto_req = 1'b0;
    bit hold     = 1'b0;
    int ack_mode = 1;
    int d_rv_cnt = 0;
    int order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own  = 0;
        m_cnt  = 0;
        m_fin  = 0;
        m_last = 1;
    endtask

    task automatic check_outputs();
        logic [31:0] base, e_addr;
        bit ack_d;
        base   = (m_own == 1) ? i_addr : d_addr;
        e_addr = (m_own != 0) ? (base & LINE_MASK) + 32'(4 * m_cnt) : 32'h0;
        ack_d  = (m_own == 2) && mem_ack;
        check("mem_req",     32'(mem_req),     32'(m_own != 0));
        check("mem_we",      32'(mem_we),      32'((m_own == 2) && d_we));
        check("mem_addr",    mem_addr,         e_addr);
        check("mem_wdata",   mem_wdata,        ((m_own == 2) && d_we) ? d_wdata : 32'h0);
        check("i_rvalid",    32'(i_rvalid),    32'((m_own == 1) && mem_ack));
        check("d_rvalid",    32'(d_rvalid),    32'(ack_d && !d_we));
        check("d_wready",    32'(d_wready),    32'(ack_d && d_we));
        check("i_done",      32'(i_done),      32'(m_fin == 1));
        check("d_done",      32'(d_done),      32'(m_fin == 2));
        check("cache_stall", 32'(cache_stall),
              32'(rst_n && ((m_own != 0) || ((m_fin == 0) && (i_req || d_req)))));
        check("i_rdata",     i_rdata,          mem_rdata);
        check("d_rdata",     d_rdata,          mem_rdata);
        seen_idone = i_done;
        seen_ddone = d_done;
        seen_wr    = d_wready;
        if (d_rvalid) d_rv_cnt++;
        if (i_done) order.push_back(1);
        if (d_done) order.push_back(2);
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (m_fin != 0) begin
            m_fin = 0;
        end else if (m_own != 0) begin
            if (mem_ack) begin
                m_cnt++;
                if (m_cnt == LW) begin
                    m_fin = m_own;
                    m_own = 0;
                    m_cnt = 0;
                end
            end
        end else if (i_req || d_req) begin
            if (i_req && d_req) m_own = (m_last == 1) ? 2 : 1;
            else                m_own = i_req ? 1 : 2;
            m_last = m_own;
        end
    endtask

    task automatic drive();
        if (i_req && seen_idone && !hold) i_req = 1'b0;
        else if (!i_req && auto_req && $urandom_range(0, 3) == 0) begin
            i_req  = 1'b1;
            i_addr = $urandom;
        end
        if (d_req && seen_ddone && !hold) d_req = 1'b0;
        else if (!d_req && auto_req && $urandom_range(0, 3) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        if (seen_wr) d_wdata = $urandom;
        case (ack_mode)
            0:       mem_ack = 1'($urandom_range(0, 1));
            1:       mem_ack = 1'b1;
            default: mem_ack = ~mem_ack;
        endcase
        mem_rdata = $urandom;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        drive();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        cycle();
        cycle();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset held with a pending I request: everything quiet, grant follows release
        i_req  = 1'b1;
        i_addr = 32'h1004;
        mem_ack = 1'b1;
        cycle();
        cycle();
        #2 rst_n = 1'b1;
        cycle();
        cycle();
        check("gnt_after_rst", 32'(mem_req), 32'h1);
        for (int k = 0; k < 8; k++) cycle();
        check("i_refill_done", 32'(order.size()), 32'h1);

        // D writeback, memory acks every other cycle
        order.delete();
        ack_mode = 2;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hA5A5_0001;
        for (int k = 0; k < 14; k++) cycle();
        check("d_wb_done", 32'(order.size()), 32'h1);

        // Simultaneous requests right after reset: D first, then I
        do_reset();
        order.delete();
        ack_mode = 1;
        i_req  = 1'b1; i_addr = 32'h4010;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h5020;
        for (int k = 0; k < 30 && order.size() < 2; k++) cycle();
        check("tie_count", 32'(order.size()), 32'h2);
        if (order.size() >= 2) begin
            check("tie_first",  32'(order[0]), 32'h2);
            check("tie_second", 32'(order[1]), 32'h1);
        end

        // Both held continuously: grants alternate D,I,D,I
        do_reset();
        order.delete();
        hold = 1'b1;
        ack_mode = 0;
        i_req = 1'b1; i_addr = 32'h0000_6000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_7000;
        for (int k = 0; k < 120 && order.size() < 4; k++) cycle();
        check("fair_count", 32'(order.size()), 32'h4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            check("fair_order", 32'(order[k]), (k % 2 == 0) ? 32'h2 : 32'h1);
        hold = 1'b0;
        for (int k = 0; k < 60 && (i_req || d_req); k++) cycle();
        check("fair_drain", 32'(i_req || d_req), 32'h0);

        // Reset in the middle of a D refill abandons the burst
        do_reset();
        order.delete();
        ack_mode = 1;
        d_rv_cnt = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        for (int k = 0; k < 10 && d_rv_cnt < 2; k++) cycle();
        check("mid_beats", 32'(d_rv_cnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'h0);
        check("mid_rst_stall",   32'(cache_stall), 32'h0);
        check("mid_rst_rvalid",  32'(d_rvalid), 32'h0);
        model_reset();
        d_req = 1'b0;
        cycle();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("mid_no_done", 32'(order.size()), 32'h0);
        d_req = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        check("mid_rerun_done", 32'(order.size()), 32'h1);

        // Random traffic with random acks, including acks while idle
        ack_mode = 0;
        auto_req = 1'b1;
        for (int k = 0; k < 800; k++) cycle();
        auto_req = 1'b0;
        for (int k = 0; k < 80 && (i_req || d_req); k++) cycle();
        check("rand_drain", 32'(i_req || d_req), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
